// File: rtl/dm_pkg.sv
// Shared types for the MEM-stage data memory: access size, fault code and init FSM state.
package dm_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_e;
    typedef enum logic [1:0] {F_NONE, F_MISAL, F_RANGE, F_SIZE} fault_e;
    typedef enum logic {INIT, READY} state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for the data memory: store byte-enables/data and extended load data.
module dm_lane_align
    import dm_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] rshift;

    assign rshift = rword >> {lane, 3'b000};

    // Store data is replicated across lanes; the byte-enable picks the live copy.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = '0;
        unique case (size)
            SZ_B: begin
                be         = 4'b0001 << lane;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
            end
            SZ_H: begin
                be         = 4'b0011 << lane;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
            end
            SZ_W: begin
                be         = 4'b1111;
                rdata_ext  = rword;
            end
            default: begin
                be         = 4'b0000;
                rdata_ext  = '0;
            end
        endcase
    end

endmodule

// File: rtl/dm_byte_ctrl.sv
// MEM-stage data memory with byte/half/word access, fault detection and a post-reset clear sweep.
module dm_byte_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter bit          LOG_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        en,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    logic [31:0] ram [Words];

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;

    size_e                 size_t;
    fault_e                fault_t;
    logic [DEPTH_LOG2-1:0] widx;
    logic [31:0]           rword, merged, wdata_lane, rdata_ext;
    logic [3:0]            be;
    logic                  active, out_of_range, misaligned, commit;

    assign size_t = size_e'(size);
    assign widx   = addr[DEPTH_LOG2+1:2];
    assign rword  = ram[widx];

    dm_lane_align u_align (
        .size       (size_t),
        .lane       (addr[1:0]),
        .sign_ext   (sign_ext),
        .wdata      (wdata),
        .rword      (rword),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == INIT) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == '1) begin
                state_d = READY;
            end
        end
    end

    always_comb begin
        busy = (state_q == INIT);
    end

    assign active       = en & ~busy;
    assign out_of_range = (addr >> (DEPTH_LOG2 + 2)) != '0;
    assign misaligned   = ((size_t == SZ_H) && addr[0]) ||
                          ((size_t == SZ_W) && (addr[1:0] != 2'b00));

    always_comb begin
        fault_t = F_NONE;
        if (active) begin
            if (size_t == SZ_RSV) begin
                fault_t = F_SIZE;
            end else if (out_of_range) begin
                fault_t = F_RANGE;
            end else if (misaligned) begin
                fault_t = F_MISAL;
            end
        end
    end

    assign fault      = (fault_t != F_NONE);
    assign fault_code = fault_t;
    assign commit     = active & we & ~fault;
    // Reads the pre-edge word, so a same-cycle store is seen only on the next cycle.
    assign rdata      = (active && !fault) ? rdata_ext : '0;

    always_comb begin
        merged = rword;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata_lane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            ram[clr_idx_q] <= '0;
        end else if (commit) begin
            ram[widx] <= merged;
            if (LOG_EN) begin
                $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
            end
        end
    end

endmodule

// File: tb/tb_dm_byte_ctrl.sv
// Scoreboard bench for dm_byte_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_dm_byte_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        en;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    dm_byte_ctrl #(.DEPTH_LOG2(12), .LOG_EN(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .en         (en),
        .we         (we),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic [1:0]  code;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    logic [31:0] mem [int unsigned];
    bit          tb_busy;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Behavioural model: 16 KiB byte-addressed memory, words default to zero.
    task automatic model(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [1:0] code);
        int unsigned k, lane;
        logic [31:0] word, v, mask;
        k    = a / 4;
        lane = a % 4;
        code = 2'd0;
        rd   = '0;
        if (sz == 2'd3) code = 2'd3;
        else if (a >= 32'h4000) code = 2'd2;
        else if ((sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)) code = 2'd1;
        if (code != 2'd0) return;
        word = mem.exists(k) ? mem[k] : 32'd0;
        if (sz == 2'd0) begin
            v = (word >> (8 * lane)) & 32'hFF;
            if (sx && v >= 32'd128) v = v - 32'd256;
            mask = 32'hFF << (8 * lane);
        end else if (sz == 2'd1) begin
            v = (word >> (8 * lane)) & 32'hFFFF;
            if (sx && v >= 32'd32768) v = v - 32'd65536;
            mask = 32'hFFFF << (8 * lane);
        end else begin
            v    = word;
            mask = 32'hFFFF_FFFF;
        end
        rd = v;
        if (w) mem[k] = (word & ~mask) | ((wd << (8 * lane)) & mask);
    endtask

    // Called at posedge+1; holds the request for one cycle.
    task automatic op(input string name, input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      input bit force_exp = 1'b0, input logic [31:0] want_rd = '0,
                      input logic [1:0] want_code = '0);
        exp_t e;
        logic [31:0] mrd;
        logic [1:0]  mcode;
        if (tb_busy) begin
            mrd   = '0;
            mcode = 2'd0;
        end else begin
            model(w, sz, sx, a, wd, mrd, mcode);
        end
        e.rd   = force_exp ? want_rd : mrd;
        e.code = force_exp ? want_code : mcode;
        exp_q.push_back(e);
        name_q.push_back(name);
        en = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 10000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("no_expectation", 32'd1, 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    check({nm, ".rdata"}, rdata, e.rd);
                    check({nm, ".fault"}, {31'd0, fault}, {31'd0, e.code != 2'd0});
                    check({nm, ".code"}, {30'd0, fault_code}, {30'd0, e.code});
                end
            end
        end
    end

    initial begin : driver
        int n;
        reset = 1'b0; en = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = '0; wdata = '0; pc = '0;
        tb_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd1);
        op("in_reset_load", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        reset = 1'b1;
        wait_sweep(n);
        check("sweep_len", n, 32'd4096);
        tb_busy = 1'b0;
        mem.delete();
        check("ready_busy", {31'd0, busy}, 32'd0);

        op("poison_sw", 1'b1, 2'd2, 1'b0, 32'h3FFC, 32'hCAFE_BABE);
        op("poison_lw", 1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0, 1'b1, 32'hCAFE_BABE, 2'd0);

        // Second reset, a dropped store mid-sweep, then a restart after 100 cycles.
        reset = 1'b0;
        tb_busy = 1'b1;
        mem.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        op("stall_sw", 1'b1, 2'd2, 1'b0, 32'h80, 32'h1234_5678);
        op("stall_lw", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        repeat (98) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        check("restart_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_sweep(n);
        check("restart_sweep_len", n, 32'd4096);
        tb_busy = 1'b0;

        op("poison_cleared", 1'b0, 2'd2, 1'b0, 32'h3FFC, 32'h0, 1'b1, 32'h0, 2'd0);
        op("stall_dropped", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0, 2'd0);

        op("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        op("sb_12", 1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AA);
        op("lw_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11AA_3344, 2'd0);
        op("lb_12", 1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b1, 32'hFFFF_FFAA, 2'd0);
        op("lbu_12", 1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0000_00AA, 2'd0);

        op("sw_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'hA5A5_1234);
        op("sh_22", 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001);
        op("lh_22", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, 32'hFFFF_8001, 2'd0);
        op("lhu_22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0000_8001, 2'd0);
        op("lhu_20", 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0000_1234, 2'd0);
        op("lw_20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h8001_1234, 2'd0);

        op("sw_13_misal", 1'b1, 2'd2, 1'b0, 32'h13, 32'hFFFF_FFFF, 1'b1, 32'h0, 2'd1);
        op("lw_10_kept", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11AA_3344, 2'd0);
        op("lh_4001_range", 1'b0, 2'd1, 1'b1, 32'h4001, 32'h0, 1'b1, 32'h0, 2'd2);
        op("rsv_4001", 1'b0, 2'd3, 1'b0, 32'h4001, 32'h0, 1'b1, 32'h0, 2'd3);
        op("rsv_10_store", 1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF, 1'b1, 32'h0, 2'd3);
        op("lw_10_after_rsv", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'h11AA_3344, 2'd0);

        op("sw_30_old", 1'b1, 2'd2, 1'b0, 32'h30, 32'h0102_0304);
        op("sw_30_rdw", 1'b1, 2'd2, 1'b0, 32'h30, 32'h5566_7788, 1'b1, 32'h0102_0304, 2'd0);
        op("lw_30_new", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b1, 32'h5566_7788, 2'd0);

        pc = 32'h3000;
        op("trace_sw", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF);
        op("trace_lw", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD_BEEF, 2'd0);

        for (int i = 0; i < 400; i++) begin
            int unsigned r, s;
            logic [31:0] a;
            logic [1:0]  sz;
            r = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else if (r == 1) a = 32'h3FF0 + $urandom_range(0, 31);
            else a = $urandom_range(0, 127);
            s = $urandom_range(0, 9);
            sz = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
            pc = $urandom;
            op("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
